// File: rtl/mips_pkg.sv
// Shared constants and the next-PC select encoding for the fetch stage.
package mips_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INCR  = 32'h0000_0004;

    // Next-PC source, listed lowest to highest priority.
    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_HOLD   = 3'd1,
        PC_BRANCH = 3'd2,
        PC_JUMP   = 3'd3,
        PC_JR     = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection. Redirect targets have their low two bits
// cleared, and any non-zero low bits are flagged so that the fetch stage can
// register a misaligned pulse. Sequential and hold values are always aligned.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] pc_plus4,
    input  logic [3:0]            pc_region,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jump_reg,
    input  logic [DATA_WIDTH-1:0] jump_reg_target,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  misaligned
);

    pc_sel_e               sel_s;
    logic [DATA_WIDTH-1:0] raw_target_s;
    logic                  redirect_s;

    // Priority encode the PC source; redirects outrank stall.
    always_comb begin
        sel_s = PC_SEQ;
        if (jump_reg) begin
            sel_s = PC_JR;
        end else if (jump) begin
            sel_s = PC_JUMP;
        end else if (branch_taken) begin
            sel_s = PC_BRANCH;
        end else if (stall) begin
            sel_s = PC_HOLD;
        end else begin
            sel_s = PC_SEQ;
        end
    end

    // Pick the raw target for the selected source and note whether it is a redirect.
    always_comb begin
        raw_target_s = pc_plus4;
        redirect_s   = 1'b0;
        case (sel_s)
            PC_JR: begin
                raw_target_s = jump_reg_target;
                redirect_s   = 1'b1;
            end
            PC_JUMP: begin
                raw_target_s = {pc_region, jump_index, 2'b00};
                redirect_s   = 1'b1;
            end
            PC_BRANCH: begin
                raw_target_s = branch_target;
                redirect_s   = 1'b1;
            end
            PC_HOLD: begin
                raw_target_s = pc;
                redirect_s   = 1'b0;
            end
            PC_SEQ: begin
                raw_target_s = pc_plus4;
                redirect_s   = 1'b0;
            end
            default: begin
                raw_target_s = pc_plus4;
                redirect_s   = 1'b0;
            end
        endcase
    end

    // Force word alignment on redirects and flag a misaligned target.
    always_comb begin
        next_pc    = raw_target_s;
        misaligned = 1'b0;
        if (redirect_s) begin
            next_pc    = {raw_target_s[DATA_WIDTH-1:2], 2'b00};
            misaligned = (raw_target_s[1:0] != 2'b00);
        end else begin
            next_pc    = raw_target_s;
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC driving the asynchronous program ROM
// and registers the returned word with its PC+4 into the IF/ID register.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jump_reg,
    input  logic [DATA_WIDTH-1:0] jump_reg_target,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] if_id_instruction_r;
    logic [DATA_WIDTH-1:0] if_id_pc_plus4_r;
    logic                  if_id_valid_r;
    logic                  misaligned_r;

    logic [DATA_WIDTH-1:0] pc_plus4_s;
    logic [DATA_WIDTH-1:0] next_pc_s;
    logic                  misaligned_s;

    // Wraps modulo 2^DATA_WIDTH.
    assign pc_plus4_s = pc_r + PC_INCR[DATA_WIDTH-1:0];

    pc_next_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pc_next_mux (
        .pc              (pc_r),
        .pc_plus4        (pc_plus4_s),
        .pc_region       (if_id_pc_plus4_r[DATA_WIDTH-1:DATA_WIDTH-4]),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_index      (jump_index),
        .jump_reg        (jump_reg),
        .jump_reg_target (jump_reg_target),
        .next_pc         (next_pc_s),
        .misaligned      (misaligned_s)
    );

    // PC register and one-cycle misaligned flag; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= RESET_PC[DATA_WIDTH-1:0];
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= next_pc_s;
            misaligned_r <= misaligned_s;
        end
    end

    // IF/ID register: flush inserts a bubble, stall holds, otherwise load the fetched word.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instruction_r <= NOP_WORD[DATA_WIDTH-1:0];
            if_id_pc_plus4_r    <= RESET_PC[DATA_WIDTH-1:0];
            if_id_valid_r       <= 1'b0;
        end else if (flush) begin
            if_id_instruction_r <= NOP_WORD[DATA_WIDTH-1:0];
            if_id_pc_plus4_r    <= pc_plus4_s;
            if_id_valid_r       <= 1'b0;
        end else if (stall) begin
            if_id_instruction_r <= if_id_instruction_r;
            if_id_pc_plus4_r    <= if_id_pc_plus4_r;
            if_id_valid_r       <= if_id_valid_r;
        end else begin
            if_id_instruction_r <= instruction_i;
            if_id_pc_plus4_r    <= pc_plus4_s;
            if_id_valid_r       <= 1'b1;
        end
    end

    assign pc_o              = pc_r;
    assign if_id_instruction = if_id_instruction_r;
    assign if_id_pc_plus4    = if_id_pc_plus4_r;
    assign if_id_valid       = if_id_valid_r;
    assign misaligned        = misaligned_r;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage. The ROM is modelled as a fixed
// combinational function of pc_o; every expected value is written out by hand.
module tb_pc_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_target;
    logic [31:0] instruction_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misaligned;

    int vectors;
    int miscompares;

    pc_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_index        (jump_index),
        .jump_reg          (jump_reg),
        .jump_reg_target   (jump_reg_target),
        .instruction_i     (instruction_i),
        .pc_o              (pc_o),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .misaligned        (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous ROM model: word = address XOR a fixed pattern.
    assign instruction_i = pc_o ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic [31:0] e_p4, input logic e_v, input logic e_mis);
        chk({tag, ".pc"},    pc_o,                      e_pc);
        chk({tag, ".instr"}, if_id_instruction,         e_ins);
        chk({tag, ".pc4"},   if_id_pc_plus4,            e_p4);
        chk({tag, ".valid"}, {31'd0, if_id_valid},      {31'd0, e_v});
        chk({tag, ".mis"},   {31'd0, misaligned},       {31'd0, e_mis});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        stall           = 1'b0;
        flush           = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = 32'h0000_0000;
        jump            = 1'b0;
        jump_index      = 26'h000_0000;
        jump_reg        = 1'b0;
        jump_reg_target = 32'h0000_0000;

        // Reset state.
        tick();
        chk_state("reset", 32'h0040_0000, 32'h0000_0000, 32'h0040_0000, 1'b0, 1'b0);
        reset = 1'b0;

        // Free-running fetch: A at 0x00400000, then B at 0x00400004.
        tick();
        chk_state("seqA", 32'h0040_0004, 32'hA5E5_0000, 32'h0040_0004, 1'b1, 1'b0);
        tick();
        chk_state("seqB", 32'h0040_0008, 32'hA5E5_0004, 32'h0040_0008, 1'b1, 1'b0);

        // Stall two cycles at pc 0x00400008.
        stall = 1'b1;
        tick();
        chk_state("stall1", 32'h0040_0008, 32'hA5E5_0004, 32'h0040_0008, 1'b1, 1'b0);
        tick();
        chk_state("stall2", 32'h0040_0008, 32'hA5E5_0004, 32'h0040_0008, 1'b1, 1'b0);
        stall = 1'b0;
        tick();
        chk_state("seqC", 32'h0040_000C, 32'hA5E5_0008, 32'h0040_000C, 1'b1, 1'b0);

        // Taken branch with flush from pc 0x0040000C.
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0020;
        flush         = 1'b1;
        tick();
        chk_state("brflush", 32'h0040_0020, 32'h0000_0000, 32'h0040_0010, 1'b0, 1'b0);
        branch_taken = 1'b0;
        flush        = 1'b0;
        tick();
        chk_state("brtgt", 32'h0040_0024, 32'hA5E5_0020, 32'h0040_0024, 1'b1, 1'b0);

        // jump_reg outranks jump.
        jump            = 1'b1;
        jump_index      = 26'h3FF_FFFF;
        jump_reg        = 1'b1;
        jump_reg_target = 32'h0040_0040;
        tick();
        chk_state("jr_over_j", 32'h0040_0040, 32'hA5E5_0024, 32'h0040_0028, 1'b1, 1'b0);
        jump     = 1'b0;
        jump_reg = 1'b0;
        tick();
        chk_state("seq44", 32'h0040_0044, 32'hA5E5_0040, 32'h0040_0044, 1'b1, 1'b0);

        // Jump alone: region bits from if_id_pc_plus4 = 0x00400044.
        jump       = 1'b1;
        jump_index = 26'h010_0010;
        tick();
        chk_state("jump", 32'h0040_0040, 32'hA5E5_0044, 32'h0040_0048, 1'b1, 1'b0);
        jump = 1'b0;

        // Misaligned branch under stall: redirect wins, low bits cleared, one-cycle flag.
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0013;
        stall         = 1'b1;
        tick();
        chk_state("misbr", 32'h0040_0010, 32'hA5E5_0044, 32'h0040_0048, 1'b1, 1'b1);
        branch_taken = 1'b0;
        stall        = 1'b0;
        tick();
        chk_state("misbr_next", 32'h0040_0014, 32'hA5E5_0010, 32'h0040_0014, 1'b1, 1'b0);

        // Misaligned jump_reg to the top word, then wrap of PC+4 to zero.
        jump_reg        = 1'b1;
        jump_reg_target = 32'hFFFF_FFFE;
        tick();
        chk_state("jrtop", 32'hFFFF_FFFC, 32'hA5E5_0014, 32'h0040_0018, 1'b1, 1'b1);
        jump_reg = 1'b0;
        tick();
        chk_state("wrap", 32'h0000_0000, 32'h5A5A_FFFC, 32'h0000_0000, 1'b1, 1'b0);

        // Reset with a misaligned taken branch and flush pending.
        reset         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0040_0083;
        flush         = 1'b1;
        tick();
        chk_state("rst_redir", 32'h0040_0000, 32'h0000_0000, 32'h0040_0000, 1'b0, 1'b0);
        reset        = 1'b0;
        branch_taken = 1'b0;
        flush        = 1'b0;
        tick();
        chk_state("post_rst", 32'h0040_0004, 32'hA5E5_0000, 32'h0040_0004, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the program ROM.
- Owns the program counter and drives the ROM byte address.
- Takes the returned instruction combinationally and registers it, with its PC+4, into the IF/ID pipeline register.
- Handles sequential fetch, branch, jump and jump-register redirects, and pipeline stall and flush from the hazard unit.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction words
RESET_PC, 32'h0040_0000, PC value loaded by reset (MIPS text base)
NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on flush

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID contents (load-use hazard)
flush  input  1  replace the next IF/ID load with a bubble
branch_taken  input  1  redirect to branch_target
branch_target  input  DATA_WIDTH  full byte address from the branch adder
jump  input  1  J/JAL redirect
jump_index  input  26  instr[25:0] of the jump in ID
jump_reg  input  1  JR redirect
jump_reg_target  input  DATA_WIDTH  rs value
instruction_i  input  DATA_WIDTH  ROM read data for pc_o
pc_o  output  DATA_WIDTH  current PC, drives ROM Address
if_id_instruction  output  DATA_WIDTH  registered instruction
if_id_pc_plus4  output  DATA_WIDTH  registered PC+4 of that instruction
if_id_valid  output  1  1 = real instruction, 0 = bubble
misaligned  output  1  one-cycle pulse: selected redirect target had [1:0] != 0

Behaviour:
- Reset, sampled on the clk edge, sets:
  - pc_o = RESET_PC
  - if_id_instruction = NOP_WORD
  - if_id_pc_plus4 = RESET_PC
  - if_id_valid = 0
  - misaligned = 0
- Reset dominates every other input.
- pc_plus4 = pc_o + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0.
- The ROM is asynchronous, so instruction_i for pc_o is valid in the same cycle. Fetch latency is 1 clk from PC update to IF/ID output.
- Next-PC select, highest priority first:
  - jump_reg: jump_reg_target
  - jump: {if_id_pc_plus4[31:28], jump_index, 2'b00}
  - branch_taken: branch_target
  - stall: pc_o (hold)
  - otherwise: pc_plus4
- Redirects override stall: a resolved control transfer is never lost.
- Misaligned target: if the selected redirect target has [1:0] != 0:
  - the PC loads the target with bits [1:0] forced to 00;
  - misaligned is registered high for exactly one cycle.
  - Sequential PCs are always aligned.
- IF/ID update, highest priority first:
  - flush: instruction = NOP_WORD, pc_plus4 = pc_plus4, valid = 0
  - stall: hold all three fields
  - otherwise: instruction = instruction_i, pc_plus4 = pc_plus4, valid = 1
- flush together with stall: flush wins, so the bubble is inserted and the PC is held unless a redirect is also present.
- A redirect without flush still loads the wrong-path instruction. The hazard unit asserts flush alongside a taken redirect; the block does not infer a flush.
- Reset mid-stall or mid-redirect: on the next edge all state returns to the reset values, and the pending redirect is discarded.
- No FSM beyond the PC and IF/ID registers. Sequential state is:
  - PC register
  - 3-field IF/ID register
  - misaligned flop

Decomposition:
- Shared package (mips_pkg):
  - RESET_PC and NOP_WORD constants
  - PC_INCR = 4
  - next-PC select encoding: PC_SEQ, PC_HOLD, PC_BRANCH, PC_JUMP, PC_JR
- One sub-module, pc_next_mux: purely combinational priority selection, alignment masking and misaligned detect. The PC and IF/ID registers stay in pc_fetch_stage.

Test Plan:
- Reset, then 3 free-running clocks with ROM words A,B,C at 0x00400000/04/08 -> pc_o goes 0x00400000, 0x00400004, 0x00400008, 0x0040000C. IF/ID shows A/0x00400004/valid=1, then B, then C.
- stall held 2 cycles at pc_o=0x00400008 -> pc_o and IF/ID frozen both cycles. On release, pc_o = 0x0040000C.
- branch_taken with branch_target=0x00400020 plus flush -> next pc_o = 0x00400020, if_id_valid = 0, if_id_instruction = 0x00000000. The following cycle loads the instruction at 0x00400020 with valid = 1.
- jump and jump_reg together, jump_reg_target=0x00400040 -> pc_o = 0x00400040. Then jump alone with jump_index=0x0100010 and if_id_pc_plus4=0x00400044 -> pc_o = 0x00400040.
- branch_target=0x00400013 with stall=1 -> pc_o = 0x00400010 despite the stall, misaligned high for exactly 1 cycle.
- reset asserted in the same cycle as branch_taken and flush -> pc_o = 0x00400000, if_id_valid = 0, misaligned = 0.
